// File: rtl/cu_pkg.sv
// Shared encodings and types for the RV32 pipelined control unit.
package cu_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  // funct7 variants
  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [6:0] F7MulDiv = 7'b0000001;

  // 4-bit base ALU codes
  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [3:0] AluAnd   = 4'b0010;
  localparam logic [3:0] AluOr    = 4'b0011;
  localparam logic [3:0] AluSrl   = 4'b0100;
  localparam logic [3:0] AluSlt   = 4'b0101;
  localparam logic [3:0] AluPassB = 4'b0110;
  localparam logic [3:0] AluSll   = 4'b0111;
  localparam logic [3:0] AluXor   = 4'b1000;
  localparam logic [3:0] AluSra   = 4'b1001;
  localparam logic [3:0] AluSltu  = 4'b1010;

  // Writeback source select
  localparam logic [1:0] ResAlu = 2'b00;
  localparam logic [1:0] ResMem = 2'b01;
  localparam logic [1:0] ResPc4 = 2'b10;
  localparam logic [1:0] ResMd  = 2'b11;

  // Immediate formats
  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  // Control bundle carried from Decode into Execute
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] result_src;
    logic [3:0] alu_ctrl;
    logic [2:0] mem_size;
    logic       md_op;
    logic [2:0] md_funct;
  } ctrl_t;

  // Shared funct3 -> ALU mapping for R-type and I-type ALU ops
  function automatic logic [3:0] alu_op_decode(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_unit_pipe_md_sequencer.sv
// Multi-cycle MUL/DIV sequencer: stalls the front end for the op latency, then
// pulses done for one cycle.
module md_sequencer
  import cu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_flush,
  input  logic       i_md_op,
  input  logic       i_md_div,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = (MaxLat < 1) ? 1 : $clog2(MaxLat + 1);

  md_state_t         r_state;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_lat;

  assign w_lat = i_md_div ? CntW'(DIV_LAT) : CntW'(MUL_LAT);

  // Busy is raised in the IDLE entry cycle as well, so total busy time equals
  // the latency; the counter therefore only covers the remaining LAT-1 cycles.
  assign o_busy = ((r_state == IDLE) && i_md_op) || (r_state == BUSY);
  assign o_done = (r_state == DONE);

  // State and down-counter; flush aborts the op with no done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (i_flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_md_op) begin
            if (w_lat <= CntW'(1)) begin
              r_state <= DONE;
            end else begin
              r_cnt   <= w_lat - CntW'(1);
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (r_cnt <= CntW'(1)) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/control_unit_pipe.sv
// Pipelined control unit: Decode-stage decoder, Decode->Execute control
// register and the MUL/DIV stall sequencer.
module control_unit_pipe
  import cu_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 4,
  parameter bit          EN_M_EXT   = 1'b1,
  parameter int unsigned MUL_LAT    = 3,
  parameter int unsigned DIV_LAT    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  stallD,
  input  logic                  flushE,
  output logic [2:0]            ImmSrcD,
  output logic                  IllegalD,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic                  ALUSrcAE,
  output logic                  ALUSrcBE,
  output logic [1:0]            ResultSrcE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic [2:0]            MemSizeE,
  output logic                  MdOpE,
  output logic [2:0]            MdFunctE,
  output logic                  MdBusy,
  output logic                  MdDone
);

  ctrl_t      w_dec;
  logic [2:0] w_imm_src;
  logic       w_illegal;
  ctrl_t      r_ctrl;
  logic       w_md_busy;
  logic       w_md_done;

  // Combinational decode; any illegal encoding collapses to a NOP
  always_comb begin
    w_dec     = '0;
    w_imm_src = '0;
    w_illegal = 1'b0;
    case (opcode)
      OpR: begin
        if (funct7 == F7MulDiv) begin
          if (EN_M_EXT) begin
            w_dec.reg_write  = 1'b1;
            w_dec.result_src = ResMd;
            w_dec.md_op      = 1'b1;
            w_dec.md_funct   = funct3;
            w_dec.alu_ctrl   = AluAdd;
          end else begin
            w_illegal = 1'b1;
          end
        end else if ((funct7 == F7Base) ||
                     ((funct7 == F7Alt) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          w_dec.reg_write = 1'b1;
          w_dec.alu_ctrl  = alu_op_decode(funct3, funct7[5]);
        end else begin
          w_illegal = 1'b1;
        end
      end
      OpI: begin
        // Shift-immediates carry funct7 in the immediate; addi must never see alt
        if (((funct3 == 3'b001) && (funct7 != F7Base)) ||
            ((funct3 == 3'b101) && (funct7 != F7Base) && (funct7 != F7Alt))) begin
          w_illegal = 1'b1;
        end else begin
          w_dec.reg_write = 1'b1;
          w_dec.alu_src_b = 1'b1;
          w_dec.alu_ctrl  = alu_op_decode(funct3, (funct3 == 3'b101) && funct7[5]);
          w_imm_src       = ImmI;
        end
      end
      OpLoad: begin
        if ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)) begin
          w_illegal = 1'b1;
        end else begin
          w_dec.reg_write  = 1'b1;
          w_dec.alu_src_b  = 1'b1;
          w_dec.result_src = ResMem;
          w_dec.mem_size   = funct3;
          w_dec.alu_ctrl   = AluAdd;
          w_imm_src        = ImmI;
        end
      end
      OpJalr: begin
        if (funct3 != 3'b000) begin
          w_illegal = 1'b1;
        end else begin
          w_dec.reg_write  = 1'b1;
          w_dec.alu_src_b  = 1'b1;
          w_dec.jump       = 1'b1;
          w_dec.result_src = ResPc4;
          w_dec.alu_ctrl   = AluAdd;
          w_imm_src        = ImmI;
        end
      end
      OpStore: begin
        if (funct3[2] || (funct3[1:0] == 2'b11)) begin
          w_illegal = 1'b1;
        end else begin
          w_dec.mem_write = 1'b1;
          w_dec.alu_src_b = 1'b1;
          w_dec.mem_size  = funct3;
          w_dec.alu_ctrl  = AluAdd;
          w_imm_src       = ImmS;
        end
      end
      OpBranch: begin
        if ((funct3 == 3'b010) || (funct3 == 3'b011)) begin
          w_illegal = 1'b1;
        end else begin
          w_dec.branch = 1'b1;
          w_imm_src    = ImmB;
          case (funct3[2:1])
            2'b00:   w_dec.alu_ctrl = AluSub;
            2'b10:   w_dec.alu_ctrl = AluSlt;
            default: w_dec.alu_ctrl = AluSltu;
          endcase
        end
      end
      OpLui: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src_b = 1'b1;
        w_dec.alu_ctrl  = AluPassB;
        w_imm_src       = ImmU;
      end
      OpAuipc: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src_a = 1'b1;
        w_dec.alu_src_b = 1'b1;
        w_dec.alu_ctrl  = AluAdd;
        w_imm_src       = ImmU;
      end
      OpJal: begin
        w_dec.reg_write  = 1'b1;
        w_dec.jump       = 1'b1;
        w_dec.result_src = ResPc4;
        w_imm_src        = ImmJ;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_dec     = '0;
      w_imm_src = '0;
    end
  end

  // Execute control register: flush beats M-unit hold, hold beats bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl <= '0;
    end else if (flushE) begin
      r_ctrl <= '0;
    end else if (w_md_busy) begin
      r_ctrl <= r_ctrl;
    end else if (stallD) begin
      r_ctrl <= '0;
    end else begin
      r_ctrl <= w_dec;
    end
  end

  md_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_flush  (flushE),
    .i_md_op  (r_ctrl.md_op),
    .i_md_div (r_ctrl.md_funct[2]),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done)
  );

  assign ImmSrcD     = w_imm_src;
  assign IllegalD    = w_illegal;
  assign RegWriteE   = r_ctrl.reg_write;
  assign MemWriteE   = r_ctrl.mem_write;
  assign JumpE       = r_ctrl.jump;
  assign BranchE     = r_ctrl.branch;
  assign ALUSrcAE    = r_ctrl.alu_src_a;
  assign ALUSrcBE    = r_ctrl.alu_src_b;
  assign ResultSrcE  = r_ctrl.result_src;
  assign ALUControlE = ALU_CTRL_W'(r_ctrl.alu_ctrl);
  assign MemSizeE    = r_ctrl.mem_size;
  assign MdOpE       = r_ctrl.md_op;
  assign MdFunctE    = r_ctrl.md_funct;
  assign MdBusy      = w_md_busy;
  assign MdDone      = w_md_done;

endmodule
